// File: rtl/fetch_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fetch_ctrl_if                                                   |
// | Purpose  : Bundles the PC, instruction-memory, decode and redirect signals |
// |            of the fetch controller.                                        |
// | Modports : master - the fetch controller (drives PC control, memory       |
// |                     request, instruction and counters)                    |
// |            slave  - the surrounding PC / memory / decode environment       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface fetch_ctrl_if;
   // PC side
   logic [31:0] pc_addr;
   logic        pc_rst;
   logic        inc_pc;
   logic        jump;
   logic [31:0] jump_addr;
   logic        branch;
   logic [31:0] branch_addr;
   // instruction memory read handshake
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   // decode handshake and redirect request
   logic [31:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic        redir_jump;
   logic        redir_branch;
   logic [31:0] redir_target;
   // statistics
   logic [31:0] fetch_cnt;
   logic [7:0]  err_cnt;

   modport master (
      input  pc_addr, mem_ack, mem_rdata, instr_ready,
             redir_jump, redir_branch, redir_target,
      output pc_rst, inc_pc, jump, jump_addr, branch, branch_addr,
             mem_req, mem_addr, instr, instr_valid, fetch_cnt, err_cnt
   );

   modport slave (
      output pc_addr, mem_ack, mem_rdata, instr_ready,
             redir_jump, redir_branch, redir_target,
      input  pc_rst, inc_pc, jump, jump_addr, branch, branch_addr,
             mem_req, mem_addr, instr, instr_valid, fetch_cnt, err_cnt
   );
endinterface
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fetch_ctrl                                                      |
// | Purpose  : Instruction fetch sequencer. Resets the PC, requests each       |
// |            instruction from memory (with timeout/retry), hands it to      |
// |            decode, applies any jump/branch redirect and strobes the PC.   |
// | Ports    : clk  - single clock, all state changes on its rising edge      |
// |            rst  - synchronous active-low reset                             |
// |            bus  - fetch_ctrl_if.master (PC control, memory handshake,      |
// |                   decode handshake, redirect inputs, fetch/error counters)|
// | Params   : TIMEOUT - FETCH cycles to wait for mem_ack before retry (2..255)|
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module fetch_ctrl #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic         clk,
   input  logic         rst,
   fetch_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_RETRY = 3'd2,
      S_HOLD  = 3'd3,
      S_SETUP = 3'd4,
      S_PULSE = 3'd5
   } state_t;

   // Wait counter value of the last FETCH cycle before a timeout
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   state_t      state_q,       state_d;
   logic        pc_rst_q,      pc_rst_d;
   logic        inc_pc_q,      inc_pc_d;
   logic        jump_q,        jump_d;
   logic [31:0] jump_addr_q,   jump_addr_d;
   logic        branch_q,      branch_d;
   logic [31:0] branch_addr_q, branch_addr_d;
   logic        mem_req_q,     mem_req_d;
   logic [31:0] mem_addr_q,    mem_addr_d;
   logic [31:0] instr_q,       instr_d;
   logic        instr_valid_q, instr_valid_d;
   logic [31:0] fetch_cnt_q,   fetch_cnt_d;
   logic [7:0]  err_cnt_q,     err_cnt_d;
   logic [7:0]  wait_q,        wait_d;

   always_comb begin
      state_d       = state_q;
      pc_rst_d      = pc_rst_q;
      inc_pc_d      = inc_pc_q;
      jump_d        = jump_q;
      jump_addr_d   = jump_addr_q;
      branch_d      = branch_q;
      branch_addr_d = branch_addr_q;
      mem_req_d     = mem_req_q;
      mem_addr_d    = mem_addr_q;
      instr_d       = instr_q;
      instr_valid_d = instr_valid_q;
      fetch_cnt_d   = fetch_cnt_q;
      err_cnt_d     = err_cnt_q;
      wait_d        = wait_q;

      case (state_q)
         S_IDLE: begin
            // pc_rst has been high since reset; the PC now holds 0
            pc_rst_d   = 1'b0;
            mem_addr_d = bus.pc_addr;
            mem_req_d  = 1'b1;
            wait_d     = 8'd0;
            state_d    = S_FETCH;
         end
         S_FETCH: begin
            // An ack on the final wait cycle still completes the fetch
            if (bus.mem_ack) begin
               instr_d       = bus.mem_rdata;
               instr_valid_d = 1'b1;
               mem_req_d     = 1'b0;
               state_d       = S_HOLD;
            end else if (wait_q == WAIT_LAST) begin
               mem_req_d = 1'b0;
               if (err_cnt_q != 8'hFF) begin
                  err_cnt_d = err_cnt_q + 8'd1;
               end
               state_d   = S_RETRY;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         S_RETRY: begin
            // Re-request the same mem_addr after a one-cycle gap
            mem_req_d = 1'b1;
            wait_d    = 8'd0;
            state_d   = S_FETCH;
         end
         S_HOLD: begin
            if (bus.instr_ready) begin
               instr_valid_d = 1'b0;
               fetch_cnt_d   = fetch_cnt_q + 32'd1;
               // Jump wins over branch so the two are never both set
               if (bus.redir_jump) begin
                  jump_d      = 1'b1;
                  jump_addr_d = bus.redir_target;
               end else if (bus.redir_branch) begin
                  branch_d      = 1'b1;
                  branch_addr_d = bus.redir_target;
               end
               state_d = S_SETUP;
            end
         end
         S_SETUP: begin
            // jump/branch and their addresses have been stable for a full
            // cycle before the PC sees the strobe
            inc_pc_d = 1'b1;
            state_d  = S_PULSE;
         end
         S_PULSE: begin
            // The PC updated on the inc_pc rising edge, so pc_addr is current
            inc_pc_d   = 1'b0;
            jump_d     = 1'b0;
            branch_d   = 1'b0;
            mem_addr_d = bus.pc_addr;
            mem_req_d  = 1'b1;
            wait_d     = 8'd0;
            state_d    = S_FETCH;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= S_IDLE;
         pc_rst_q      <= 1'b1;
         inc_pc_q      <= 1'b0;
         jump_q        <= 1'b0;
         jump_addr_q   <= 32'd0;
         branch_q      <= 1'b0;
         branch_addr_q <= 32'd0;
         mem_req_q     <= 1'b0;
         mem_addr_q    <= 32'd0;
         instr_q       <= 32'd0;
         instr_valid_q <= 1'b0;
         fetch_cnt_q   <= 32'd0;
         err_cnt_q     <= 8'd0;
         wait_q        <= 8'd0;
      end else begin
         state_q       <= state_d;
         pc_rst_q      <= pc_rst_d;
         inc_pc_q      <= inc_pc_d;
         jump_q        <= jump_d;
         jump_addr_q   <= jump_addr_d;
         branch_q      <= branch_d;
         branch_addr_q <= branch_addr_d;
         mem_req_q     <= mem_req_d;
         mem_addr_q    <= mem_addr_d;
         instr_q       <= instr_d;
         instr_valid_q <= instr_valid_d;
         fetch_cnt_q   <= fetch_cnt_d;
         err_cnt_q     <= err_cnt_d;
         wait_q        <= wait_d;
      end
   end

   assign bus.pc_rst      = pc_rst_q;
   assign bus.inc_pc      = inc_pc_q;
   assign bus.jump        = jump_q;
   assign bus.jump_addr   = jump_addr_q;
   assign bus.branch      = branch_q;
   assign bus.branch_addr = branch_addr_q;
   assign bus.mem_req     = mem_req_q;
   assign bus.mem_addr    = mem_addr_q;
   assign bus.instr       = instr_q;
   assign bus.instr_valid = instr_valid_q;
   assign bus.fetch_cnt   = fetch_cnt_q;
   assign bus.err_cnt     = err_cnt_q;

endmodule
`default_nettype wire
